fifo_write_arbiter: RTL and testbench

Round-robin arbiter that shares the single write port of the async FIFO among `num_Req` requesters in the write clock domain. Each requester gets a valid/ready handshake. The block drives the FIFO's `w_Inc`/`write_Data` combinationally from the granted requester, gated by the FIFO's own `fifo_Full`, so overflow cannot occur. Grants are burst-based: a requester keeps the port for up to `max_Burst` accepted words, then must re-arbitrate.

---
 rtl/fifo_write_arbiter.sv | 134 +++++++++++++
 tb/tb_fifo_write_arbiter.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : fifo_write_arbiter
// Summary  : Burst-based round-robin arbiter sharing one async-FIFO write port
//            among num_Req valid/ready requesters in the write clock domain.
// Revision : 1.0 - initial release
// =============================================================================
module fifo_write_arbiter #(
    parameter int data_Size = 8,
    parameter int num_Req   = 4,
    parameter int max_Burst = 4
) (
    input  logic                         w_Clk,
    input  logic                         w_Rst,
    input  logic [num_Req-1:0]           req_Valid,
    input  logic [num_Req*data_Size-1:0] req_Data,
    output logic [num_Req-1:0]           req_Ready,
    input  logic                         fifo_Full,
    output logic                         w_Inc,
    output logic [data_Size-1:0]         write_Data,
    output logic [num_Req-1:0]           grant,
    output logic [$clog2(num_Req)-1:0]   grant_Id,
    output logic                         busy
);

    localparam int c_ID_W  = $clog2(num_Req);
    localparam int c_CNT_W = $clog2(max_Burst + 1);
    localparam logic [c_CNT_W-1:0] c_MAX_BEATS = c_CNT_W'(max_Burst);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [num_Req-1:0]   r_grant;
    logic [num_Req-1:0]   w_grant_nxt;
    logic [c_ID_W-1:0]    r_grant_id;
    logic [c_ID_W-1:0]    w_grant_id_nxt;
    logic [c_ID_W-1:0]    r_last_grant;
    logic [c_ID_W-1:0]    w_last_grant_nxt;
    logic [c_CNT_W-1:0]   r_beat_count;
    logic [c_CNT_W-1:0]   w_beat_count_nxt;

    logic                 w_rr_found;
    logic [c_ID_W-1:0]    w_rr_winner;
    logic [c_ID_W-1:0]    w_rr_cand;
    logic                 w_busy;
    logic                 w_sel_valid;
    logic                 w_accept;
    logic [data_Size-1:0] w_slice [num_Req];

    for (genvar gi = 0; gi < num_Req; gi++) begin : g_slice
        assign w_slice[gi] = req_Data[gi*data_Size +: data_Size];
    end

    // Search upward from the requester after the last owner, wrapping modulo num_Req.
    always_comb begin
        w_rr_found  = 1'b0;
        w_rr_winner = '0;
        w_rr_cand   = '0;
        for (int k = 1; k <= num_Req; k++) begin
            w_rr_cand = c_ID_W'((int'(r_last_grant) + k) % num_Req);
            if (!w_rr_found && req_Valid[w_rr_cand]) begin
                w_rr_found  = 1'b1;
                w_rr_winner = w_rr_cand;
            end
        end
    end

    assign w_busy      = (r_state == S_BURST);
    assign w_sel_valid = req_Valid[r_grant_id];
    assign w_accept    = w_busy & w_sel_valid & ~fifo_Full;

    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_grant_id_nxt   = r_grant_id;
        w_last_grant_nxt = r_last_grant;
        w_beat_count_nxt = r_beat_count;
        case (r_state)
            S_IDLE: begin
                if (w_rr_found) begin
                    w_state_nxt      = S_BURST;
                    w_grant_nxt      = {{(num_Req-1){1'b0}}, 1'b1} << w_rr_winner;
                    w_grant_id_nxt   = w_rr_winner;
                    w_beat_count_nxt = '0;
                end
            end
            S_BURST: begin
                // A dropped valid releases even while the FIFO is full.
                if (!w_sel_valid ||
                    (w_accept && ((r_beat_count + 1'b1) == c_MAX_BEATS))) begin
                    w_state_nxt      = S_IDLE;
                    w_last_grant_nxt = r_grant_id;
                    w_grant_nxt      = '0;
                    w_grant_id_nxt   = '0;
                    w_beat_count_nxt = '0;
                end else if (w_accept) begin
                    w_beat_count_nxt = r_beat_count + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge w_Clk) begin
        if (w_Rst) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_grant_id   <= '0;
            r_last_grant <= c_ID_W'(num_Req - 1);
            r_beat_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_grant_id   <= w_grant_id_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_beat_count <= w_beat_count_nxt;
        end
    end

    assign busy       = w_busy;
    assign grant      = r_grant;
    assign grant_Id   = r_grant_id;
    assign req_Ready  = r_grant & {num_Req{~fifo_Full}};
    assign w_Inc      = w_accept;
    assign write_Data = w_busy ? w_slice[r_grant_id] : '0;

endmodule
`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : tb_fifo_write_arbiter
// Summary  : Self-checking bench: directed scenarios plus random traffic
//            compared against a transaction-level arbitration model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_fifo_write_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int MB = 4;
    localparam int IW = $clog2(NR);

    logic              w_Clk = 1'b0;
    logic              w_Rst = 1'b1;
    logic [NR-1:0]     req_Valid = '0;
    logic [NR*DW-1:0]  req_Data = '0;
    logic              fifo_Full = 1'b0;
    logic [NR-1:0]     req_Ready;
    logic              w_Inc;
    logic [DW-1:0]     write_Data;
    logic [NR-1:0]     grant;
    logic [IW-1:0]     grant_Id;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 w_Clk = ~w_Clk;

    fifo_write_arbiter #(.data_Size(DW), .num_Req(NR), .max_Burst(MB)) dut (
        .w_Clk      (w_Clk),
        .w_Rst      (w_Rst),
        .req_Valid  (req_Valid),
        .req_Data   (req_Data),
        .req_Ready  (req_Ready),
        .fifo_Full  (fifo_Full),
        .w_Inc      (w_Inc),
        .write_Data (write_Data),
        .grant      (grant),
        .grant_Id   (grant_Id),
        .busy       (busy)
    );

    function automatic logic vbit(input logic [NR-1:0] v, input int i);
        return 1'(v >> i);
    endfunction

    function automatic logic [DW-1:0] dslice(input int i);
        return DW'(req_Data >> (i * DW));
    endfunction

    task automatic set_data(input int i, input logic [DW-1:0] v);
        logic [NR*DW-1:0] mask;
        mask     = {{(NR*DW-DW){1'b0}}, {DW{1'b1}}};
        req_Data = (req_Data & ~(mask << (i * DW))) | ((NR*DW)'(v) << (i * DW));
    endtask

    task automatic tick();
        @(posedge w_Clk);
        #1;
    endtask

    task automatic do_reset();
        w_Rst     = 1'b1;
        req_Valid = '0;
        fifo_Full = 1'b0;
        tick();
        w_Rst = 1'b0;
    endtask

    // Reference model: who owns the port, who owned it last, beats taken.
    int m_owner = -1;
    int m_last  = NR - 1;
    int m_beats = 0;

    always @(posedge w_Clk) begin
        if (w_Rst) begin
            m_owner = -1;
            m_last  = NR - 1;
            m_beats = 0;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= NR; k++)
                if (m_owner < 0 && vbit(req_Valid, (m_last + k) % NR))
                    m_owner = (m_last + k) % NR;
            m_beats = 0;
        end else if (!vbit(req_Valid, m_owner)) begin
            m_last  = m_owner;
            m_owner = -1;
            m_beats = 0;
        end else if (!fifo_Full) begin
            m_beats = m_beats + 1;
            if (m_beats == MB) begin
                m_last  = m_owner;
                m_owner = -1;
                m_beats = 0;
            end
        end
    end

    task automatic test_reset();
        w_Rst     = 1'b1;
        req_Valid = '1;
        fifo_Full = 1'b0;
        tick();
        tick();
        @(negedge w_Clk);
        n_tests++;
        if ({grant, busy, w_Inc, write_Data} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: grant=%b busy=%b w_Inc=%b write_Data=%h, required all zero",
                     grant, busy, w_Inc, write_Data);
        end
        n_tests++;
        if (req_Ready !== '0) begin
            n_fail++;
            $display("FAIL reset_ready: req_Ready=%b, required 0000", req_Ready);
        end
        w_Rst = 1'b0;
        tick();
        @(negedge w_Clk);
        n_tests++;
        if (grant !== 4'b0001 || grant_Id !== 2'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_grant: grant=%b grant_Id=%0d busy=%b, required 0001/0/1",
                     grant, grant_Id, busy);
        end
    endtask

    task automatic test_single();
        int idx = 0, cur = 0, first = -1, last = -1, cyc = 0;
        int lens[$];
        logic [DW-1:0] got[$];
        logic prev_busy = 1'b0, gid_ok = 1'b1, acc, data_ok;
        do_reset();
        req_Valid = 4'b0100;
        set_data(2, 8'h20);
        while (idx < 10 && cyc < 60) begin
            @(negedge w_Clk);
            if (busy && grant_Id !== 2'd2) gid_ok = 1'b0;
            if (prev_busy && !busy) begin lens.push_back(cur); cur = 0; end
            prev_busy = busy;
            acc = w_Inc;
            if (w_Inc) begin
                if (first < 0) first = cyc;
                last = cyc;
                cur++;
                got.push_back(write_Data);
            end
            tick();
            cyc++;
            if (acc) begin idx++; set_data(2, 8'(8'h20 + idx)); end
        end
        req_Valid = '0;
        repeat (3) begin
            @(negedge w_Clk);
            if (prev_busy && !busy) begin lens.push_back(cur); cur = 0; end
            prev_busy = busy;
            if (w_Inc) got.push_back(write_Data);
            tick();
        end
        data_ok = (got.size() == 10);
        for (int i = 0; i < got.size(); i++)
            if (got[i] !== 8'(8'h20 + i)) data_ok = 1'b0;
        n_tests++;
        if (!data_ok) begin
            n_fail++;
            $display("FAIL single_data: %0d writes (first %h), required 10 writes 20..29",
                     got.size(), (got.size() > 0) ? got[0] : 8'h00);
        end
        n_tests++;
        if (lens.size() != 3 || lens[0] != 4 || lens[1] != 4 || lens[2] != 2) begin
            n_fail++;
            $display("FAIL single_bursts: %0d bursts (%0d,%0d,%0d), required 3 bursts 4,4,2",
                     lens.size(), (lens.size() > 0) ? lens[0] : -1,
                     (lens.size() > 1) ? lens[1] : -1, (lens.size() > 2) ? lens[2] : -1);
        end
        n_tests++;
        if (last - first != 11) begin
            n_fail++;
            $display("FAIL single_bubbles: write span %0d cycles, required 11", last - first);
        end
        n_tests++;
        if (!gid_ok) begin
            n_fail++;
            $display("FAIL single_grant_id: grant_Id not 2 during a burst, required 2");
        end
    endtask

    task automatic test_contend();
        int ids[$];
        int cycs[$];
        int cnt[NR];
        logic [NR-1:0] acc;
        logic ok = 1'b1;
        do_reset();
        req_Valid = '1;
        for (int i = 0; i < NR; i++) set_data(i, 8'($urandom));
        for (int c = 0; c < 30; c++) begin
            @(negedge w_Clk);
            acc = req_Valid & req_Ready;
            if (w_Inc) begin ids.push_back(int'(grant_Id)); cycs.push_back(c); end
            tick();
            for (int i = 0; i < NR; i++) if (vbit(acc, i)) set_data(i, 8'($urandom));
        end
        if (ids.size() < 20) ok = 1'b0;
        for (int j = 0; j < 20 && j < ids.size(); j++)
            if (ids[j] != (j / 4) % NR) ok = 1'b0;
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL contend_order: %0d writes, 5th owner %0d, required order 0,1,2,3 in runs of 4",
                     ids.size(), (ids.size() > 4) ? ids[4] : -1);
        end
        for (int i = 0; i < NR; i++) cnt[i] = 0;
        for (int j = 0; j < ids.size(); j++)
            if (cycs[j] >= cycs[0] && cycs[j] < cycs[0] + 20) cnt[ids[j]]++;
        for (int i = 0; i < NR; i++) begin
            n_tests++;
            if (cnt[i] != 4) begin
                n_fail++;
                $display("FAIL contend_share_%0d: %0d writes in 20-cycle window, required 4", i, cnt[i]);
            end
        end
    endtask

    task automatic test_full_stall();
        int cnt = 0, guard = 0;
        logic a, ok = 1'b1, fell = 1'b0;
        do_reset();
        req_Valid = 4'b0010;
        set_data(1, 8'h50);
        while (cnt < 2 && guard < 10) begin
            @(negedge w_Clk);
            a = w_Inc;
            if (a) cnt++;
            tick();
            guard++;
            if (a) set_data(1, 8'(8'h50 + cnt));
        end
        fifo_Full = 1'b1;
        repeat (5) begin
            @(negedge w_Clk);
            if (w_Inc !== 1'b0 || req_Ready !== '0 || busy !== 1'b1) ok = 1'b0;
            tick();
        end
        n_tests++;
        if (!ok || cnt != 2) begin
            n_fail++;
            $display("FAIL stall_hold: beats before stall %0d, stall clean %b, required 2 and 1", cnt, ok);
        end
        fifo_Full = 1'b0;
        guard = 0;
        while (!fell && guard < 10) begin
            @(negedge w_Clk);
            a = 1'b0;
            if (!busy) fell = 1'b1;
            else begin a = w_Inc; if (a) cnt++; end
            tick();
            guard++;
            if (a) set_data(1, 8'(8'h50 + cnt));
        end
        n_tests++;
        if (cnt != 4 || !fell) begin
            n_fail++;
            $display("FAIL stall_total: %0d beats, released %b, required 4 and 1", cnt, fell);
        end
    endtask

    task automatic test_early_release();
        do_reset();
        req_Valid = 4'b0001;
        set_data(0, 8'h11);
        tick();
        @(negedge w_Clk);
        n_tests++;
        if (grant_Id !== 2'd0 || w_Inc !== 1'b1) begin
            n_fail++;
            $display("FAIL early_setup: grant_Id=%0d w_Inc=%b, required 0/1", grant_Id, w_Inc);
        end
        tick();
        req_Valid = 4'b1010;
        set_data(1, 8'h21);
        set_data(3, 8'h31);
        tick();
        tick();
        @(negedge w_Clk);
        n_tests++;
        if (grant_Id !== 2'd1 || w_Inc !== 1'b1 || write_Data !== 8'h21) begin
            n_fail++;
            $display("FAIL early_grant1: grant_Id=%0d w_Inc=%b data=%h, required 1/1/21",
                     grant_Id, w_Inc, write_Data);
        end
        tick();
        req_Valid = 4'b1000;
        tick();
        @(negedge w_Clk);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL early_bubble: busy=%b, required 0", busy);
        end
        tick();
        @(negedge w_Clk);
        n_tests++;
        if (grant_Id !== 2'd3 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL early_next: grant_Id=%0d busy=%b, required 3/1", grant_Id, busy);
        end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        logic found = 1'b0;
        do_reset();
        req_Valid = 4'b0101;
        set_data(0, 8'h0A);
        set_data(2, 8'h2A);
        while (!found && guard < 20) begin
            @(negedge w_Clk);
            if (busy && grant_Id == 2'd2) found = 1'b1;
            else begin tick(); guard++; end
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL rmid_reach: requester 2 granted=%b within 20 cycles, required 1", found);
        end
        tick();
        @(negedge w_Clk);
        n_tests++;
        if (w_Inc !== 1'b1 || grant_Id !== 2'd2) begin
            n_fail++;
            $display("FAIL rmid_second_beat: w_Inc=%b grant_Id=%0d, required 1/2", w_Inc, grant_Id);
        end
        w_Rst = 1'b1;
        tick();
        w_Rst = 1'b0;
        @(negedge w_Clk);
        n_tests++;
        if (busy !== 1'b0 || w_Inc !== 1'b0 || grant !== '0) begin
            n_fail++;
            $display("FAIL rmid_dropped: busy=%b w_Inc=%b grant=%b, required 0/0/0000", busy, w_Inc, grant);
        end
        tick();
        @(negedge w_Clk);
        n_tests++;
        if (grant_Id !== 2'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_regrant: grant_Id=%0d busy=%b, required 0/1", grant_Id, busy);
        end
    endtask

    task automatic test_random();
        logic [NR-1:0] acc, e_grant, e_ready;
        logic [IW-1:0] e_gid;
        logic          e_busy, e_winc;
        logic [DW-1:0] e_data;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge w_Clk);
            e_busy  = (m_owner >= 0);
            e_grant = e_busy ? (NR'(1) << m_owner) : '0;
            e_gid   = e_busy ? IW'(m_owner) : '0;
            e_winc  = e_busy && vbit(req_Valid, m_owner) && !fifo_Full;
            e_data  = e_busy ? dslice(m_owner) : '0;
            e_ready = (e_busy && !fifo_Full) ? e_grant : '0;
            n_tests++;
            if ({busy, grant, grant_Id, w_Inc, write_Data, req_Ready} !==
                {e_busy, e_grant, e_gid, e_winc, e_data, e_ready}) begin
                n_fail++;
                $display("FAIL random_cycle_%0d: busy=%b grant=%b id=%0d inc=%b data=%h rdy=%b, required %b %b %0d %b %h %b",
                         c, busy, grant, grant_Id, w_Inc, write_Data, req_Ready,
                         e_busy, e_grant, e_gid, e_winc, e_data, e_ready);
            end
            acc = req_Valid & req_Ready;
            tick();
            for (int i = 0; i < NR; i++) begin
                if (vbit(acc, i) || !vbit(req_Valid, i)) begin
                    req_Valid = (req_Valid & ~(NR'(1) << i)) | (NR'($urandom_range(0, 2) != 0) << i);
                    set_data(i, 8'($urandom));
                end else if ($urandom_range(0, 19) == 0) begin
                    req_Valid = req_Valid & ~(NR'(1) << i);
                end
            end
            fifo_Full = ($urandom_range(0, 3) == 0);
        end
        req_Valid = '0;
        fifo_Full = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contend();
        test_full_stall();
        test_early_release();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
